// File: rtl/player_move_ctrl.sv
// player_move_ctrl: turns held arrow key codes into auto-repeating move requests
// and tracks the player's grid position and a saturating move counter.
module player_move_ctrl #(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int X_MAX        = 31,
    parameter int Y_MAX        = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] key_code,
    output logic        move_valid,
    output logic [1:0]  move_dir,
    input  logic        move_ready,
    input  logic        move_blocked,
    output logic [4:0]  player_x,
    output logic [4:0]  player_y,
    output logic [15:0] move_count,
    output logic        key_active
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
    localparam logic [24:0] DELAY_LD = 25'(REPEAT_DELAY - 1);
    localparam logic [24:0] RATE_LD  = 25'(REPEAT_RATE - 1);
    localparam logic [4:0]  XM       = 5'(X_MAX);
    localparam logic [4:0]  YM       = 5'(Y_MAX);

    state_t      state_q, state_d;
    logic [15:0] key_q, lat_code_q, lat_code_d, move_count_q, move_count_d;
    logic [1:0]  lat_dir_q, lat_dir_d, key_dir;
    logic [24:0] timer_q, timer_d;
    logic [4:0]  x_q, x_d, y_q, y_d;
    logic        first_q, first_d, key_ok, oob, legal;

    always_comb begin
        key_ok  = 1'b1;
        key_dir = 2'd0;
        case (key_q)
            16'hE075: key_dir = 2'd0;
            16'hE072: key_dir = 2'd1;
            16'hE06B: key_dir = 2'd2;
            16'hE074: key_dir = 2'd3;
            default:  key_ok  = 1'b0;
        endcase
    end

    // Edges of the grid act like walls: no wrap-around.
    assign oob = (lat_dir_q == 2'd0 && y_q == 5'd0) || (lat_dir_q == 2'd1 && y_q == YM) ||
                 (lat_dir_q == 2'd2 && x_q == 5'd0) || (lat_dir_q == 2'd3 && x_q == XM);
    assign legal = state_q == ISSUE && move_ready && !move_blocked && !oob;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            key_q        <= '0;
            lat_code_q   <= '0;
            lat_dir_q    <= '0;
            first_q      <= 1'b0;
            timer_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            move_count_q <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_code;
            lat_code_q   <= lat_code_d;
            lat_dir_q    <= lat_dir_d;
            first_q      <= first_d;
            timer_q      <= timer_d;
            x_q          <= x_d;
            y_q          <= y_d;
            move_count_q <= move_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_code_d = lat_code_q;
        lat_dir_d  = lat_dir_q;
        first_d    = first_q;
        timer_d    = timer_q;
        case (state_q)
            IDLE: if (key_ok) begin
                state_d    = ISSUE;
                lat_code_d = key_q;
                lat_dir_d  = key_dir;
                first_d    = 1'b1;
            end
            ISSUE: if (move_ready) begin
                state_d = HOLD;
                timer_d = first_q ? DELAY_LD : RATE_LD;
                first_d = 1'b0;
            end
            HOLD: begin
                if (key_q != lat_code_q) state_d = IDLE;
                else if (timer_q == '0) state_d = ISSUE;
                else timer_d = timer_q - 25'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        move_count_d = move_count_q;
        if (legal) begin
            case (lat_dir_q)
                2'd0:    y_d = y_q - 5'd1;
                2'd1:    y_d = y_q + 5'd1;
                2'd2:    x_d = x_q - 5'd1;
                default: x_d = x_q + 5'd1;
            endcase
            move_count_d = move_count_q == 16'hFFFF ? move_count_q : move_count_q + 16'd1;
        end
    end

    always_comb begin
        move_valid = state_q == ISSUE;
        key_active = state_q != IDLE;
        move_dir   = lat_dir_q;
        player_x   = x_q;
        player_y   = y_q;
        move_count = move_count_q;
    end
endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl: vector table, directed timing/boundary sequences and a
// randomized run against an event-time reference model of player_move_ctrl.
module tb_player_move_ctrl;
    localparam int D = 10, R = 4, XM = 31, YM = 23;

    typedef struct {
        logic        r;
        logic [15:0] kc;
        logic        rd, bl, ev;
        logic [1:0]  ed;
        logic [4:0]  ex;
        logic [15:0] ec;
        logic        ea;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, move_ready, move_blocked, move_valid, key_active;
    logic [15:0] key_code, move_count;
    logic [1:0]  move_dir;
    logic [4:0]  player_x, player_y;
    int          passed = 0, total = 0;

    int          m_kq, m_lat, m_pend, m_first, m_due, m_x, m_y, m_cnt, m_dir, m_cyc;
    vec_t        tv[14];
    int          req[$];
    int          exp_req[7] = '{2, 13, 18, 23, 28, 33, 38};
    logic [15:0] arrows[4] = '{16'hE075, 16'hE072, 16'hE06B, 16'hE074};
    logic [15:0] kc_r;
    logic        r_r, rd_r, bl_r;
    int          n, hold;

    always #5 clk = ~clk;

    player_move_ctrl #(.REPEAT_DELAY(D), .REPEAT_RATE(R), .X_MAX(XM), .Y_MAX(YM)) dut (
        .clk(clk), .reset(reset), .key_code(key_code), .move_valid(move_valid),
        .move_dir(move_dir), .move_ready(move_ready), .move_blocked(move_blocked),
        .player_x(player_x), .player_y(player_y), .move_count(move_count), .key_active(key_active)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_all(input string nm, input int ev, input int ed, input int ex,
                             input int ey, input int ec, input int ea);
        chk({nm, "_valid"}, int'(move_valid), ev);
        chk({nm, "_dir"}, int'(move_dir), ed);
        chk({nm, "_x"}, int'(player_x), ex);
        chk({nm, "_y"}, int'(player_y), ey);
        chk({nm, "_cnt"}, int'(move_count), ec);
        chk({nm, "_active"}, int'(key_active), ea);
    endtask

    task automatic tick(input logic r, input logic [15:0] kc, input logic rd, input logic bl);
        reset = r;
        key_code = kc;
        move_ready = rd;
        move_blocked = bl;
        @(posedge clk);
        #1;
    endtask

    function automatic int dir_of(input int code);
        case (code)
            'hE075:  return 0;
            'hE072:  return 1;
            'hE06B:  return 2;
            'hE074:  return 3;
            default: return -1;
        endcase
    endfunction

    // Reference: a pending request, a latched key, and the absolute edge index at which the next repeat fires.
    task automatic model_step(input logic r, input int kc, input logic rd, input logic bl);
        int nx, ny;
        if (r) begin
            m_kq = 0; m_lat = -1; m_pend = 0; m_first = 0; m_due = 0;
            m_x = 0; m_y = 0; m_cnt = 0; m_dir = 0;
        end else begin
            if (m_lat < 0) begin
                if (dir_of(m_kq) >= 0) begin
                    m_lat = m_kq; m_dir = dir_of(m_kq); m_pend = 1; m_first = 1;
                end
            end else if (m_pend != 0) begin
                if (rd) begin
                    nx = m_x + (m_dir == 3 ? 1 : m_dir == 2 ? -1 : 0);
                    ny = m_y + (m_dir == 1 ? 1 : m_dir == 0 ? -1 : 0);
                    if (!bl && nx >= 0 && nx <= XM && ny >= 0 && ny <= YM) begin
                        m_x = nx; m_y = ny;
                        if (m_cnt < 65535) m_cnt++;
                    end
                    m_due = m_cyc + (m_first != 0 ? D : R);
                    m_first = 0; m_pend = 0;
                end
            end else if (m_kq != m_lat) m_lat = -1;
            else if (m_cyc == m_due) m_pend = 1;
            m_kq = kc;
        end
        m_cyc++;
    endtask

    initial begin
        reset = 1'b1; key_code = '0; move_ready = 1'b0; move_blocked = 1'b0;
        tv[0]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 16'd0, 1'b0};
        tv[1]  = '{1'b0, 16'hE074, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 16'd0, 1'b0};
        tv[2]  = '{1'b0, 16'hE074, 1'b1, 1'b0, 1'b1, 2'd3, 5'd0, 16'd0, 1'b1};
        tv[3]  = '{1'b0, 16'hE074, 1'b1, 1'b0, 1'b0, 2'd3, 5'd1, 16'd1, 1'b1};
        tv[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd3, 5'd1, 16'd1, 1'b1};
        tv[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd3, 5'd1, 16'd1, 1'b0};
        tv[6]  = '{1'b0, 16'hE06B, 1'b0, 1'b0, 1'b0, 2'd3, 5'd1, 16'd1, 1'b0};
        tv[7]  = '{1'b0, 16'hE06B, 1'b0, 1'b0, 1'b1, 2'd2, 5'd1, 16'd1, 1'b1};
        tv[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd2, 5'd1, 16'd1, 1'b1};
        tv[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd2, 5'd1, 16'd1, 1'b1};
        tv[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd2, 5'd1, 16'd1, 1'b1};
        tv[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd2, 5'd1, 16'd1, 1'b1};
        tv[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd2, 5'd1, 16'd1, 1'b0};
        tv[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd2, 5'd1, 16'd1, 1'b0};
        for (int i = 0; i < 14; i++) begin
            tick(tv[i].r, tv[i].kc, tv[i].rd, tv[i].bl);
            check_all($sformatf("vec%0d", i), int'(tv[i].ev), int'(tv[i].ed), int'(tv[i].ex),
                      0, int'(tv[i].ec), int'(tv[i].ea));
        end

        // Auto-repeat schedule with right held and ready tied high.
        tick(1'b1, 16'h0000, 1'b0, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            tick(1'b0, 16'hE074, 1'b1, 1'b0);
            if (move_valid) req.push_back(c);
            if (c == 2) chk("rep_first_dir", int'(move_dir), 3);
        end
        chk("rep_count", req.size(), 7);
        for (int k = 0; k < 7; k++) chk($sformatf("rep_cycle%0d", k), k < req.size() ? req[k] : -1, exp_req[k]);
        chk("rep_x", int'(player_x), 7);
        chk("rep_cnt", int'(move_count), 7);

        // Left at x=0, then down all the way into the bottom edge.
        tick(1'b1, 16'h0000, 1'b0, 1'b0);
        n = 0;
        for (int c = 1; c <= 4; c++) begin
            tick(1'b0, 16'hE06B, 1'b1, 1'b0);
            if (move_valid) n++;
        end
        chk("left_reqs", n, 1);
        chk("left_x", int'(player_x), 0);
        chk("left_cnt", int'(move_count), 0);
        repeat (2) tick(1'b0, 16'h0000, 1'b1, 1'b0);
        n = 0;
        for (int c = 1; c <= 130; c++) begin
            tick(1'b0, 16'hE072, 1'b1, 1'b0);
            if (move_valid) n++;
        end
        chk("down_reqs", n, 25);
        chk("down_y", int'(player_y), YM);
        chk("down_cnt", int'(move_count), YM);
        chk("down_x", int'(player_x), 0);

        // Direction change while holding up.
        repeat (3) tick(1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (3) tick(1'b0, 16'hE075, 1'b1, 1'b0);
        chk("up_y", int'(player_y), YM - 1);
        repeat (3) tick(1'b0, 16'hE075, 1'b1, 1'b0);
        n = 0;
        do begin
            tick(1'b0, 16'hE072, 1'b0, 1'b0);
            n++;
        end while (!move_valid && n < 8);
        chk("chg_latency", n, 3);
        chk("chg_dir", int'(move_dir), 1);
        n = 0;
        do begin
            tick(1'b0, 16'hE072, 1'b1, 1'b0);
            n++;
        end while (!move_valid && n < 30);
        chk("chg_gap", n, D + 1);
        chk("chg_y", int'(player_y), YM);

        // Move counter saturation.
        repeat (3) tick(1'b0, 16'h0000, 1'b1, 1'b0);
        force dut.move_count_q = 16'hFFFE;
        tick(1'b0, 16'h0000, 1'b0, 1'b0);
        release dut.move_count_q;
        chk("force_cnt", int'(move_count), 'hFFFE);
        for (int c = 1; c <= 20; c++) begin
            tick(1'b0, 16'hE074, 1'b1, 1'b0);
            if (c == 3) chk("sat_first", int'(move_count), 'hFFFF);
        end
        chk("sat_cnt", int'(move_count), 'hFFFF);
        chk("sat_x", int'(player_x), 3);

        // Reset while a request is pending.
        repeat (3) tick(1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (2) tick(1'b0, 16'hE06B, 1'b0, 1'b0);
        chk("pre_rst_valid", int'(move_valid), 1);
        tick(1'b1, 16'hE06B, 1'b1, 1'b0);
        check_all("rst_issue", 0, 0, 0, 0, 0, 0);

        // Randomized run against the reference model.
        tick(1'b1, 16'h0000, 1'b0, 1'b0);
        m_cyc = 0;
        model_step(1'b1, 0, 1'b0, 1'b0);
        hold = 0;
        kc_r = '0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 7))
                    0, 1:    kc_r = 16'h0000;
                    6:       kc_r = 16'hE000 | 16'($urandom_range(0, 255));
                    7:       kc_r = 16'($urandom);
                    default: kc_r = arrows[$urandom_range(0, 3)];
                endcase
                hold = $urandom_range(1, 40);
            end
            hold--;
            r_r  = $urandom_range(0, 499) == 0;
            rd_r = $urandom_range(0, 9) < 7;
            bl_r = $urandom_range(0, 4) == 0;
            tick(r_r, kc_r, rd_r, bl_r);
            model_step(r_r, int'(kc_r), rd_r, bl_r);
            check_all("rnd", m_pend, m_dir, m_x, m_y, m_cnt, m_lat >= 0 ? 1 : 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
